// File: rtl/func_gate_pipe_pkg.sv
// Shared control definitions for the func gate pipeline: class codes, default
// gate mask, beat layout and skid-buffer occupancy states.
package func_gate_pipe_pkg;

    localparam int unsigned CLASS_CODE_W = 10;
    localparam int unsigned BEAT_FUNC_W  = 3;

    // Bit position of each instruction class in the one-hot decoder code
    typedef enum int unsigned {
        CLS_LUI    = 0,
        CLS_AUIPC  = 1,
        CLS_OP_IMM = 2,
        CLS_JAL    = 3,
        CLS_JALR   = 4,
        CLS_OP     = 5,
        CLS_FENCE  = 6,
        CLS_BRANCH = 7,
        CLS_SYSTEM = 8,
        CLS_MEM    = 9
    } cls_idx_e;

    // Classes 0, 1, 3, 4, 6 and 8 have their func forced to zero
    localparam logic [CLASS_CODE_W-1:0] DEF_ZERO_MASK = 10'b01_0101_1011;

    typedef struct packed {
        logic [BEAT_FUNC_W-1:0]  func;
        logic [CLASS_CODE_W-1:0] code;
        logic                    illegal;
    } beat_t;

    typedef enum logic [1:0] {
        SKID_EMPTY,
        SKID_ONE,
        SKID_FULL
    } skid_state_e;

endpackage

// File: rtl/func_gate_pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer: main register drives the output,
// skid register absorbs the beat accepted while the main register is stalled.
module skid_buf
    import func_gate_pipe_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    skid_state_e  state, state_n;
    logic [W-1:0] m_data, s_data;
    logic         accept, drain;
    logic         load_m, load_s, m_from_s;

    assign accept    = in_valid && in_ready;
    assign out_valid = (state != SKID_EMPTY);
    assign drain     = out_valid && out_ready;
    assign out_data  = m_data;

    always_comb begin
        state_n  = state;
        load_m   = 1'b0;
        load_s   = 1'b0;
        m_from_s = 1'b0;
        if (flush) begin
            state_n = SKID_EMPTY;
        end else begin
            case (state)
                SKID_EMPTY: begin
                    if (accept) begin
                        load_m  = 1'b1;
                        state_n = SKID_ONE;
                    end
                end
                SKID_ONE: begin
                    if (accept && drain) begin
                        load_m = 1'b1;
                    end else if (accept) begin
                        load_s  = 1'b1;
                        state_n = SKID_FULL;
                    end else if (drain) begin
                        state_n = SKID_EMPTY;
                    end
                end
                SKID_FULL: begin
                    if (drain) begin
                        load_m   = 1'b1;
                        m_from_s = 1'b1;
                        if (accept) load_s  = 1'b1;
                        else        state_n = SKID_ONE;
                    end
                end
                default: state_n = SKID_EMPTY;
            endcase
        end
    end

    // in_ready is a flop tracking whether the skid entry will be free
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= SKID_EMPTY;
            m_data   <= '0;
            s_data   <= '0;
            in_ready <= 1'b1;
        end else begin
            state    <= state_n;
            in_ready <= (state_n != SKID_FULL);
            if (flush) begin
                m_data <= '0;
                s_data <= '0;
            end else begin
                if (load_m) m_data <= m_from_s ? s_data : in_data;
                if (load_s) s_data <= in_data;
            end
        end
    end

endmodule

// File: rtl/func_gate_pipe.sv
// Func gate between decode and execute, registered behind a skid buffer.
// Define FUNC_GATE_ONEHOT_CHK_EN to flag and zero beats whose class code is not one-hot.
module func_gate_pipe
    import func_gate_pipe_pkg::*;
#(
    parameter int unsigned          CODE_W    = CLASS_CODE_W,
    parameter int unsigned          FUNC_W    = BEAT_FUNC_W,
    parameter logic [CODE_W-1:0]    ZERO_MASK = DEF_ZERO_MASK
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CODE_W-1:0] in_code,
    input  logic [FUNC_W-1:0] in_insn,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [FUNC_W-1:0] out_func,
    output logic [CODE_W-1:0] out_code,
    output logic              out_illegal
);

    localparam int unsigned PAY_W = FUNC_W + CODE_W + 1;

    logic              masked;
    logic              illegal;
    logic [FUNC_W-1:0] func;
    logic [PAY_W-1:0]  in_pay, out_pay;

    assign masked = |(in_code & ZERO_MASK);

`ifdef FUNC_GATE_ONEHOT_CHK_EN
    // x & (x-1) clears the lowest set bit, so non-zero means two or more bits
    assign illegal = (in_code == '0) || ((in_code & (in_code - CODE_W'(1))) != '0);
`else
    assign illegal = 1'b0;
`endif

    assign func   = (masked || illegal) ? '0 : in_insn;
    assign in_pay = {func, in_code, illegal};

    skid_buf #(
        .W (PAY_W)
    ) u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_pay),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_pay)
    );

    assign {out_func, out_code, out_illegal} = out_pay;

endmodule
